banked_register_file: RTL and testbench

Parametrised successor to the CPU register file. Holds NUM_PAIRS 16-bit register pairs addressed by pair index and byte index, with one 8-bit read port, one 16-bit read port, byte/pair/flag write ports, WZ copy and RST vectoring. It adds optional same-cycle write-to-read forwarding and a save-state engine. The engine serially dumps or loads every register byte over a valid/ready byte stream, used for debugger and emulator snapshots. It sits between the decoder/control unit and the ALU/IDU datapath.

---
 rtl/banked_register_file_pkg.sv | 27 ++
 rtl/banked_register_file_if.sv | 24 ++
 rtl/banked_register_file_savestate_fsm.sv | 90 +++++++++
 rtl/banked_register_file.sv | 111 +++++++++++
 tb/tb_banked_register_file.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/banked_register_file_pkg.sv
// Shared types for the banked register file: pair indices, flag layout,
// save-state engine states and the byte-index helper.
package banked_register_file_pkg;

  localparam int PAIR_AF = 0;
  localparam int PAIR_BC = 1;
  localparam int PAIR_DE = 2;
  localparam int PAIR_HL = 3;
  localparam int PAIR_SP = 4;
  localparam int PAIR_PC = 5;
  localparam int PAIR_WZ = 6;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {IDLE, DUMP, LOAD} savestate_state_t;

  // Byte index {pair, lo}; lo=1 addresses bits [7:0] of the pair.
  function automatic int idx(input int pair, input logic lo);
    return 2 * pair + (lo ? 1 : 0);
  endfunction

endpackage

// File: rtl/banked_register_file_if.sv
// Save-state control and byte-stream handshakes between a debugger/emulator
// host (master) and the register file (slave).
interface banked_register_file_if;
  logic       dump_start;
  logic       load_start;
  logic       st_valid;
  logic       st_ready;
  logic [7:0] st_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       busy;
  logic       done;

  modport master (
    output dump_start, load_start, st_ready, ld_valid, ld_data,
    input  st_valid, st_data, ld_ready, busy, done
  );

  modport slave (
    input  dump_start, load_start, st_ready, ld_valid, ld_data,
    output st_valid, st_data, ld_ready, busy, done
  );
endinterface

// File: rtl/banked_register_file_savestate_fsm.sv
// Serial snapshot engine: streams every register byte out (DUMP) or in (LOAD),
// one byte per accepted handshake, high byte of each pair first.
module regfile_savestate_fsm
  import banked_register_file_pkg::*;
#(
  parameter  int NUM_PAIRS = 7,
  localparam int PW        = $clog2(NUM_PAIRS)
) (
  input  logic                     clk,
  input  logic                     rst,
  banked_register_file_if.slave    ss,
  input  logic [7:0]               eng_rbyte,
  output logic                     eng_we,
  output logic [PW:0]              eng_idx,
  output logic [7:0]               eng_wdata
);

  localparam int          LAST_I = 2 * NUM_PAIRS - 1;
  localparam logic [PW:0] LAST   = LAST_I[PW:0];

  savestate_state_t state_q, state_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    ss.st_valid = 1'b0;
    ss.ld_ready = 1'b0;
    eng_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss.dump_start) begin
          state_d = DUMP;
          cnt_d   = '0;
        end else if (ss.load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      DUMP: begin
        ss.st_valid = 1'b1;
        if (ss.st_ready) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD: begin
        ss.ld_ready = 1'b1;
        if (ss.ld_valid) begin
          eng_we = 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter doubles as the byte index: even counts hit the high byte.
  assign eng_idx    = cnt_q;
  assign eng_wdata  = ss.ld_data;
  assign ss.st_data = eng_rbyte;
  assign ss.busy    = (state_q != IDLE);
  assign ss.done    = done_q;

endmodule

// File: rtl/banked_register_file.sv
// CPU register file of NUM_PAIRS 16-bit pairs with byte/pair/flag writes,
// optional write-to-read forwarding and a serial save-state engine.
module banked_register_file
  import banked_register_file_pkg::*;
#(
  parameter  int          NUM_PAIRS = 7,
  parameter  bit          BYPASS    = 1'b1,
  parameter  logic [15:0] RST_BASE  = 16'h0000,
  localparam int          PW        = $clog2(NUM_PAIRS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_r,
  input  logic [PW:0]           read_idx_r,
  output logic [7:0]            data_out_r,
  input  logic                  read_rr,
  input  logic [PW-1:0]         read_pair_rr,
  input  logic                  read_ldh_rr,
  output logic [15:0]           data_out_rr,
  input  logic                  write_r,
  input  logic [PW:0]           write_idx_r,
  input  logic [7:0]            data_in_r,
  input  logic                  write_rr,
  input  logic [PW-1:0]         write_pair_rr,
  input  logic [15:0]           data_in_rr,
  input  logic                  flags_we,
  input  logic [3:0]            flag_mask_n,
  input  logic [3:0]            flags_in,
  input  logic                  copy_wz,
  input  logic [PW-1:0]         copy_pair,
  input  logic                  pc_rst,
  input  logic [2:0]            pc_rst_vector,
  output logic [7:0]            a_out,
  output logic [7:0]            h_out,
  output logic [7:0]            l_out,
  output flags_t                flags_out,
  banked_register_file_if.slave ss
);

  typedef logic [NUM_PAIRS-1:0][15:0] regs_t;

  regs_t       regs_q, regs_d, rd_src;
  logic        eng_we;
  logic [PW:0] eng_idx;
  logic [7:0]  eng_wdata, eng_rbyte;

  function automatic logic in_range(input logic [PW-1:0] p);
    return int'(p) < NUM_PAIRS;
  endfunction

  function automatic logic [7:0] byte_of(input regs_t r, input logic [PW:0] i);
    if (!in_range(i[PW:1])) return 8'h00;
    return i[0] ? r[i[PW:1]][7:0] : r[i[PW:1]][15:8];
  endfunction

  regfile_savestate_fsm #(.NUM_PAIRS(NUM_PAIRS)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .eng_rbyte (eng_rbyte),
    .eng_we    (eng_we),
    .eng_idx   (eng_idx),
    .eng_wdata (eng_wdata)
  );

  // Apply writers lowest priority first so higher ones overwrite the byte.
  always_comb begin
    regs_d = regs_q;
    if (!ss.busy) begin
      if (flags_we)
        regs_d[PAIR_AF][7:4] = (regs_q[PAIR_AF][7:4] & flag_mask_n) | (flags_in & ~flag_mask_n);
      if (write_r && in_range(write_idx_r[PW:1])) begin
        if (write_idx_r[0]) regs_d[write_idx_r[PW:1]][7:0]  = data_in_r;
        else                regs_d[write_idx_r[PW:1]][15:8] = data_in_r;
      end
      if (copy_wz && in_range(copy_pair))
        regs_d[copy_pair] = regs_q[PAIR_WZ];
      if (write_rr && in_range(write_pair_rr))
        regs_d[write_pair_rr] = data_in_rr;
      if (pc_rst)
        regs_d[PAIR_PC] = RST_BASE + {10'd0, pc_rst_vector, 3'b000};
    end
    if (eng_we && in_range(eng_idx[PW:1])) begin
      if (eng_idx[0]) regs_d[eng_idx[PW:1]][7:0]  = eng_wdata;
      else            regs_d[eng_idx[PW:1]][15:8] = eng_wdata;
    end
    regs_d[PAIR_AF][3:0] = 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  // Forwarding reads the about-to-commit value, which equals regs_q when idle.
  assign rd_src    = BYPASS ? regs_d : regs_q;
  assign eng_rbyte = byte_of(regs_q, eng_idx);

  always_comb begin
    data_out_r  = read_r ? byte_of(rd_src, read_idx_r) : 8'h00;
    data_out_rr = 16'h0000;
    if (read_rr && in_range(read_pair_rr))
      data_out_rr = read_ldh_rr ? {8'hFF, rd_src[read_pair_rr][7:0]} : rd_src[read_pair_rr];
  end

  assign a_out     = regs_q[PAIR_AF][15:8];
  assign flags_out = regs_q[PAIR_AF][7:4];
  assign h_out     = regs_q[PAIR_HL][15:8];
  assign l_out     = regs_q[PAIR_HL][7:0];

endmodule

// File: tb/tb_banked_register_file.sv
// Randomized and directed bench for banked_register_file against a byte-array
// reference model; a second instance with BYPASS=0 covers the registered read.
module tb_banked_register_file;
  import banked_register_file_pkg::*;

  localparam int NP = 7;
  localparam int PW = $clog2(NP);
  localparam int NB = 2 * NP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          read_r, read_rr, read_ldh_rr, write_r, write_rr, flags_we, copy_wz, pc_rst;
  logic [PW:0]   read_idx_r, write_idx_r;
  logic [PW-1:0] read_pair_rr, write_pair_rr, copy_pair;
  logic [7:0]    data_in_r, data_out_r, data_out_r_nb;
  logic [15:0]   data_in_rr, data_out_rr, data_out_rr_nb;
  logic [3:0]    flag_mask_n, flags_in;
  logic [2:0]    pc_rst_vector;
  logic [7:0]    a_out, h_out, l_out, a_out_nb, h_out_nb, l_out_nb;
  flags_t        flags_out, flags_out_nb;

  banked_register_file_if ssif ();
  banked_register_file_if ssif_nb ();

  banked_register_file #(.NUM_PAIRS(NP), .BYPASS(1'b1), .RST_BASE(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .read_r(read_r), .read_idx_r(read_idx_r), .data_out_r(data_out_r),
    .read_rr(read_rr), .read_pair_rr(read_pair_rr), .read_ldh_rr(read_ldh_rr), .data_out_rr(data_out_rr),
    .write_r(write_r), .write_idx_r(write_idx_r), .data_in_r(data_in_r),
    .write_rr(write_rr), .write_pair_rr(write_pair_rr), .data_in_rr(data_in_rr),
    .flags_we(flags_we), .flag_mask_n(flag_mask_n), .flags_in(flags_in),
    .copy_wz(copy_wz), .copy_pair(copy_pair), .pc_rst(pc_rst), .pc_rst_vector(pc_rst_vector),
    .a_out(a_out), .h_out(h_out), .l_out(l_out), .flags_out(flags_out), .ss(ssif.slave)
  );

  banked_register_file #(.NUM_PAIRS(NP), .BYPASS(1'b0), .RST_BASE(16'h0000)) dut_nb (
    .clk(clk), .rst(rst),
    .read_r(read_r), .read_idx_r(read_idx_r), .data_out_r(data_out_r_nb),
    .read_rr(read_rr), .read_pair_rr(read_pair_rr), .read_ldh_rr(read_ldh_rr), .data_out_rr(data_out_rr_nb),
    .write_r(write_r), .write_idx_r(write_idx_r), .data_in_r(data_in_r),
    .write_rr(write_rr), .write_pair_rr(write_pair_rr), .data_in_rr(data_in_rr),
    .flags_we(flags_we), .flag_mask_n(flag_mask_n), .flags_in(flags_in),
    .copy_wz(copy_wz), .copy_pair(copy_pair), .pc_rst(pc_rst), .pc_rst_vector(pc_rst_vector),
    .a_out(a_out_nb), .h_out(h_out_nb), .l_out(l_out_nb), .flags_out(flags_out_nb), .ss(ssif_nb.slave)
  );

  int npass = 0;
  int ntot  = 0;

  // Reference: register contents as a flat byte array, index = 2*pair + lo.
  logic [7:0] mb [NB];
  logic [7:0] nb [NB];

  function automatic logic [PW:0] bi(input int pair, input logic lo);
    int t;
    t = idx(pair, lo);
    return t[PW:0];
  endfunction

  function automatic void model_calc();
    logic [15:0] pcv;
    logic [7:0]  v;
    int          p;
    logic        lo;
    pcv = 16'h0000 + 16'(pc_rst_vector) * 16'd8;
    for (int b = 0; b < NB; b++) begin
      p  = b / 2;
      lo = (b % 2 == 1);
      v  = mb[b];
      if (pc_rst && p == PAIR_PC)                          v = lo ? pcv[7:0] : pcv[15:8];
      else if (write_rr && int'(write_pair_rr) == p)       v = lo ? data_in_rr[7:0] : data_in_rr[15:8];
      else if (copy_wz && int'(copy_pair) == p)            v = mb[idx(PAIR_WZ, lo)];
      else if (write_r && int'(write_idx_r) == b)          v = data_in_r;
      else if (flags_we && b == idx(PAIR_AF, 1'b1))        v[7:4] = (v[7:4] & flag_mask_n) | (flags_in & ~flag_mask_n);
      if (b == idx(PAIR_AF, 1'b1)) v[3:0] = 4'h0;
      nb[b] = v;
    end
  endfunction

  function automatic logic [7:0] rd8(input logic post, input int i);
    if (i >= NB) return 8'h00;
    return post ? nb[i] : mb[i];
  endfunction

  function automatic logic [15:0] rd16(input logic post, input int p, input logic ldh);
    logic [7:0] hi, lo;
    if (p >= NP) return 16'h0000;
    hi = rd8(post, 2 * p);
    lo = rd8(post, 2 * p + 1);
    return ldh ? {8'hFF, lo} : {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    model_calc();
    tick();
    for (int b = 0; b < NB; b++) mb[b] = nb[b];
  endtask

  task automatic idle_inputs();
    read_r = 0; read_idx_r = '0; read_rr = 0; read_pair_rr = '0; read_ldh_rr = 0;
    write_r = 0; write_idx_r = '0; data_in_r = '0;
    write_rr = 0; write_pair_rr = '0; data_in_rr = '0;
    flags_we = 0; flag_mask_n = '0; flags_in = '0;
    copy_wz = 0; copy_pair = '0; pc_rst = 0; pc_rst_vector = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ssif.dump_start = 0; ssif.load_start = 0; ssif.st_ready = 0; ssif.ld_valid = 0; ssif.ld_data = '0;
    rst = 1; tick(); tick(); rst = 0;
    for (int b = 0; b < NB; b++) mb[b] = 8'h00;
    read_rr = 1;
    for (int p = 0; p < NP; p++) begin
      read_pair_rr = p[PW-1:0]; #1;
      ntot++; if (data_out_rr !== 16'h0000) $display("FAIL reset_pair%0d: got %h want 0000", p, data_out_rr); else npass++;
    end
    read_rr = 0; #1;
    ntot++;
    if ({ssif.busy, ssif.done, ssif.st_valid, ssif.ld_ready} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {ssif.busy, ssif.done, ssif.st_valid, ssif.ld_ready});
    else npass++;
  endtask

  task automatic test_pair_rw();
    idle_inputs();
    write_rr = 1; write_pair_rr = PAIR_BC[PW-1:0]; data_in_rr = 16'h1234; step();
    idle_inputs();
    read_r = 1; read_idx_r = bi(PAIR_BC, 1'b0); read_rr = 1; read_pair_rr = PAIR_BC[PW-1:0]; #1;
    ntot++; if (data_out_r !== 8'h12) $display("FAIL bc_hi: got %h want 12", data_out_r); else npass++;
    ntot++; if (data_out_rr !== 16'h1234) $display("FAIL bc_pair: got %h want 1234", data_out_rr); else npass++;
    read_ldh_rr = 1; #1;
    ntot++; if (data_out_rr !== 16'hFF34) $display("FAIL ldh: got %h want ff34", data_out_rr); else npass++;
    idle_inputs();
  endtask

  task automatic test_bypass();
    idle_inputs();
    write_rr = 1; write_pair_rr = PAIR_HL[PW-1:0]; data_in_rr = 16'h1234; step();
    idle_inputs();
    write_r = 1; write_idx_r = bi(PAIR_HL, 1'b1); data_in_r = 8'h5A;
    read_r = 1; read_idx_r = bi(PAIR_HL, 1'b1); #1;
    ntot++; if (data_out_r !== 8'h5A) $display("FAIL bypass_on: got %h want 5a", data_out_r); else npass++;
    ntot++; if (data_out_r_nb !== 8'h34) $display("FAIL bypass_off: got %h want 34", data_out_r_nb); else npass++;
    step();
    idle_inputs();
  endtask

  task automatic test_priority();
    idle_inputs();
    write_rr = 1; write_pair_rr = PAIR_HL[PW-1:0]; data_in_rr = 16'hAAAA;
    write_r = 1; write_idx_r = bi(PAIR_HL, 1'b0); data_in_r = 8'h11; step();
    idle_inputs(); read_rr = 1; read_pair_rr = PAIR_HL[PW-1:0]; #1;
    ntot++; if (data_out_rr !== 16'hAAAA) $display("FAIL rr_over_r: got %h want aaaa", data_out_rr); else npass++;
    idle_inputs(); write_rr = 1; write_pair_rr = PAIR_AF[PW-1:0]; data_in_rr = 16'h0000; step();
    idle_inputs(); flags_we = 1; flag_mask_n = 4'b0110; flags_in = 4'b1111; step();
    ntot++; if (flags_out !== 4'b1001) $display("FAIL flags_mask: got %b want 1001", flags_out); else npass++;
    idle_inputs(); pc_rst = 1; pc_rst_vector = 3'd7;
    write_rr = 1; write_pair_rr = PAIR_PC[PW-1:0]; data_in_rr = 16'h4000; step();
    idle_inputs(); read_rr = 1; read_pair_rr = PAIR_PC[PW-1:0]; #1;
    ntot++; if (data_out_rr !== 16'h0038) $display("FAIL pc_rst_prio: got %h want 0038", data_out_rr); else npass++;
    idle_inputs(); write_rr = 1; write_pair_rr = PAIR_WZ[PW-1:0]; data_in_rr = 16'hBEEF; step();
    idle_inputs(); copy_wz = 1; copy_pair = PAIR_DE[PW-1:0];
    write_r = 1; write_idx_r = bi(PAIR_DE, 1'b0); data_in_r = 8'h77; step();
    idle_inputs(); read_rr = 1; read_pair_rr = PAIR_DE[PW-1:0]; #1;
    ntot++; if (data_out_rr !== 16'hBEEF) $display("FAIL copy_over_r: got %h want beef", data_out_rr); else npass++;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] r1, r2, r3;
    logic [7:0]  e8;
    logic [15:0] e16;
    for (int k = 0; k < 300; k++) begin
      r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
      write_r  = (r1[1:0] == 2'b00);   write_idx_r   = r1[2 +: PW+1];  data_in_r  = r2[23:16];
      write_rr = (r1[8:7] == 2'b00);   write_pair_rr = r1[9 +: PW];    data_in_rr = r2[15:0];
      copy_wz  = (r1[13:12] == 2'b00); copy_pair     = r1[14 +: PW];
      flags_we = (r1[18:17] == 2'b00); flag_mask_n   = r3[3:0];        flags_in   = r3[7:4];
      pc_rst   = (r1[21:19] == 3'b000); pc_rst_vector = r3[10:8];
      read_r   = r1[22]; read_idx_r   = r3[11 +: PW+1];
      read_rr  = r1[23]; read_pair_rr = r3[16 +: PW]; read_ldh_rr = r3[19];
      model_calc(); #1;
      e8 = read_r ? rd8(1'b1, int'(read_idx_r)) : 8'h00;
      ntot++; if (data_out_r !== e8) $display("FAIL rnd_rd8 k=%0d: got %h want %h", k, data_out_r, e8); else npass++;
      e16 = read_rr ? rd16(1'b1, int'(read_pair_rr), read_ldh_rr) : 16'h0000;
      ntot++; if (data_out_rr !== e16) $display("FAIL rnd_rd16 k=%0d: got %h want %h", k, data_out_rr, e16); else npass++;
      e8 = read_r ? rd8(1'b0, int'(read_idx_r)) : 8'h00;
      ntot++; if (data_out_r_nb !== e8) $display("FAIL rnd_rd8_nb k=%0d: got %h want %h", k, data_out_r_nb, e8); else npass++;
      step();
      ntot++;
      if ({a_out, h_out, l_out, flags_out} !== {mb[0], mb[6], mb[7], mb[1][7:4]})
        $display("FAIL rnd_taps k=%0d: got %h want %h", k, {a_out, h_out, l_out, flags_out}, {mb[0], mb[6], mb[7], mb[1][7:4]});
      else npass++;
    end
    idle_inputs();
  endtask

  task automatic test_dump();
    logic [7:0] first4 [4];
    logic [7:0] prev_data;
    logic       prev_stalled;
    int         got, dn;
    first4 = '{8'h01, 8'hB0, 8'h00, 8'h13};
    idle_inputs();
    write_rr = 1; write_pair_rr = PAIR_AF[PW-1:0]; data_in_rr = 16'h01B0; step();
    write_pair_rr = PAIR_BC[PW-1:0]; data_in_rr = 16'h0013; step();
    idle_inputs();
    ssif.dump_start = 1; tick(); ssif.dump_start = 0;
    got = 0; dn = 0; prev_stalled = 0; prev_data = '0;
    for (int k = 0; k < 100 && got < NB; k++) begin
      ssif.st_ready = k[0];
      write_r = (k == 3); write_idx_r = bi(PAIR_HL, 1'b1); data_in_r = 8'hEE;
      #1;
      ntot++; if (ssif.st_valid !== 1'b1 || ssif.busy !== 1'b1) $display("FAIL dump_valid: got %b%b want 11", ssif.st_valid, ssif.busy); else npass++;
      ntot++; if (ssif.st_data !== mb[got]) $display("FAIL dump_byte%0d: got %h want %h", got, ssif.st_data, mb[got]); else npass++;
      if (got < 4) begin
        ntot++; if (ssif.st_data !== first4[got]) $display("FAIL dump_first%0d: got %h want %h", got, ssif.st_data, first4[got]); else npass++;
      end
      if (prev_stalled) begin
        ntot++; if (ssif.st_data !== prev_data) $display("FAIL dump_hold: got %h want %h", ssif.st_data, prev_data); else npass++;
      end
      if (ssif.done) dn++;
      prev_stalled = !ssif.st_ready;
      prev_data    = ssif.st_data;
      if (ssif.st_ready) got++;
      tick();
    end
    ssif.st_ready = 0; write_r = 0;
    ntot++; if (got !== NB) $display("FAIL dump_count: got %0d want %0d", got, NB); else npass++;
    ntot++; if (ssif.busy !== 1'b0) $display("FAIL dump_idle: got %b want 0", ssif.busy); else npass++;
    for (int k = 0; k < 3; k++) begin
      if (ssif.done) dn++;
      tick();
    end
    ntot++; if (dn !== 1) $display("FAIL dump_done: got %0d pulses want 1", dn); else npass++;
    ntot++; if (l_out !== mb[idx(PAIR_HL, 1'b1)]) $display("FAIL busy_write: got %h want %h", l_out, mb[idx(PAIR_HL, 1'b1)]); else npass++;
  endtask

  task automatic test_load();
    logic [7:0] d;
    int         dn;
    idle_inputs();
    ssif.load_start = 1; tick(); ssif.load_start = 0;
    d = 8'h10;
    for (int b = 0; b < NB; b++) begin
      ssif.ld_valid = 1; ssif.ld_data = d; #1;
      ntot++; if (ssif.ld_ready !== 1'b1) $display("FAIL load_ready%0d: got %b want 1", b, ssif.ld_ready); else npass++;
      mb[b] = d;
      d = d + 8'h01;
      tick();
    end
    mb[1][3:0] = 4'h0;
    ssif.ld_valid = 0;
    ntot++; if ({ssif.done, ssif.busy} !== 2'b10) $display("FAIL load_done: got %b want 10", {ssif.done, ssif.busy}); else npass++;
    tick();
    ntot++; if (ssif.done !== 1'b0) $display("FAIL load_done_pulse: got %b want 0", ssif.done); else npass++;
    read_rr = 1;
    for (int p = 0; p < NP; p++) begin
      read_pair_rr = p[PW-1:0]; #1;
      ntot++; if (data_out_rr !== rd16(1'b0, p, 1'b0)) $display("FAIL load_pair%0d: got %h want %h", p, data_out_rr, rd16(1'b0, p, 1'b0)); else npass++;
    end
    read_pair_rr = PAIR_BC[PW-1:0]; #1;
    ntot++; if (data_out_rr !== 16'h1213) $display("FAIL load_bc: got %h want 1213", data_out_rr); else npass++;
    read_pair_rr = PAIR_AF[PW-1:0]; #1;
    ntot++; if (data_out_rr !== 16'h1010) $display("FAIL load_af: got %h want 1010", data_out_rr); else npass++;
    idle_inputs();
    // Second load aborted by reset after five bytes.
    ssif.load_start = 1; tick(); ssif.load_start = 0;
    for (int b = 0; b < 5; b++) begin
      ssif.ld_valid = 1; ssif.ld_data = 8'hC0; tick();
    end
    rst = 1; tick(); rst = 0; ssif.ld_valid = 0;
    for (int b = 0; b < NB; b++) mb[b] = 8'h00;
    ntot++; if ({ssif.busy, ssif.ld_ready} !== 2'b00) $display("FAIL abort_idle: got %b want 00", {ssif.busy, ssif.ld_ready}); else npass++;
    dn = 0;
    read_rr = 1;
    for (int p = 0; p < NP; p++) begin
      read_pair_rr = p[PW-1:0]; #1;
      if (ssif.done) dn++;
      ntot++; if (data_out_rr !== 16'h0000) $display("FAIL abort_pair%0d: got %h want 0000", p, data_out_rr); else npass++;
      tick();
    end
    ntot++; if (dn !== 0) $display("FAIL abort_done: got %0d pulses want 0", dn); else npass++;
    idle_inputs();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ssif_nb.dump_start = 0; ssif_nb.load_start = 0; ssif_nb.st_ready = 0;
    ssif_nb.ld_valid = 0; ssif_nb.ld_data = '0;
    rst = 1;
    test_reset();
    test_pair_rw();
    test_bypass();
    test_priority();
    test_random();
    test_dump();
    test_load();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
